// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence player and its neighbours.
package seq_pkg;

  typedef logic [2:0] symbol_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } player_state_e;

  // Symbol the detector sees whenever no pattern is being replayed.
  localparam symbol_t DEFAULT_IDLE_SYM = 3'b000;

endpackage

// File: rtl/seq_pattern_mem.sv
// Pattern register file: one write port, one asynchronous read port,
// asynchronously cleared to the idle symbol.
module seq_pattern_mem
  import seq_pkg::*;
#(
  parameter int      DEPTH    = 8,
  parameter int      AW       = 3,
  parameter symbol_t IDLE_SYM = DEFAULT_IDLE_SYM
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [2:0]    rd_data
);

  logic [DEPTH-1:0][2:0] mem_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mem_q[gi] <= IDLE_SYM;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          mem_q[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // A same-edge write and read of one entry returns the pre-write contents.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sequence_player.sv
// Replays a loaded symbol pattern once or in a loop, one symbol per clock.
// Build option SEQ_GAP_EN inserts GAP_CYCLES idle symbols between loop passes.
module sequence_player
  import seq_pkg::*;
#(
  parameter int      DEPTH      = 8,
  parameter int      AW         = 3,
  parameter symbol_t IDLE_SYM   = DEFAULT_IDLE_SYM,
  parameter int      GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic [2:0]    data,
  output logic          data_valid,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_PLAY = PLAY;
`ifdef SEQ_GAP_EN
  localparam logic [1:0] S_GAP  = GAP;
  localparam int         GCW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   len_q, len_d;
  logic          launch_q, launch_d;
  logic [2:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          go_idle;

  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data;
  logic          last;
  logic          len_ok;

  seq_pattern_mem #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .IDLE_SYM (IDLE_SYM)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ptr_q indexes the symbol currently on data; rd_addr fetches the one after it.
  assign last    = ({1'b0, ptr_q} == (len_q - {{AW{1'b0}}, 1'b1}));
  assign len_ok  = (len != '0) && (len <= (AW+1)'(DEPTH));
  assign rd_addr = ((state_q == S_PLAY) && !last) ? ptr_q + AW'(1) : '0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    launch_d = launch_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    go_idle  = 1'b0;
`ifdef SEQ_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        // An accepted start spends one cycle armed before the first symbol.
        if (launch_q) begin
          launch_d = 1'b0;
          if (!stop) begin
            state_d = S_PLAY;
            ptr_d   = '0;
            data_d  = rd_data;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end else if (start && !stop && len_ok) begin
          launch_d = 1'b1;
          len_d    = len;
          ptr_d    = '0;
        end
      end

      S_PLAY: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (last && !loop_en) begin
          go_idle = 1'b1;
          done_d  = 1'b1;
        end else if (last) begin
`ifdef SEQ_GAP_EN
          if (GAP_CYCLES > 0) begin
            state_d   = S_GAP;
            ptr_d     = '0;
            gap_cnt_d = GCW'(GAP_CYCLES - 1);
            data_d    = IDLE_SYM;
            valid_d   = 1'b0;
          end else begin
            ptr_d  = '0;
            data_d = rd_data;
          end
`else
          ptr_d  = '0;
          data_d = rd_data;
`endif
        end else begin
          ptr_d  = ptr_q + AW'(1);
          data_d = rd_data;
        end
      end

`ifdef SEQ_GAP_EN
      S_GAP: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (gap_cnt_q == '0) begin
          state_d = S_PLAY;
          ptr_d   = '0;
          data_d  = rd_data;
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GCW'(1);
        end
      end
`endif

      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d  = S_IDLE;
      ptr_d    = '0;
      launch_d = 1'b0;
      data_d   = IDLE_SYM;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      launch_q <= 1'b0;
      data_q   <= IDLE_SYM;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      launch_q <= launch_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SEQ_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
